stdp_synapse_array: RTL and testbench

- Multi-channel STDP synapse bank: N_CH presynaptic spike inputs converge on one postsynaptic neuron.
- Each channel has its own plastic weight and presynaptic trace; one postsynaptic trace is shared by all channels.
- Drives the summed, saturated synaptic current into the i_syn input of an lif_neuron.
- Adds pair-based trace-weighted LTP/LTD, a learning enable, and a host weight write/read port.

---
 rtl/stdp_synapse_array.sv | 203 ++++++++++++++++++++
 tb/tb_stdp_synapse_array.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_synapse_array.sv
// -----------------------------------------------------------------------------
// stdp_synapse_array
//
// Bank of N_CH plastic synapses converging on one postsynaptic neuron. Each
// channel keeps an unsigned weight and a presynaptic trace; a single
// postsynaptic trace is shared by all channels. Every cycle the weights of the
// channels that spiked are summed, saturated to the positive signed range and
// registered onto i_syn. With learn_en=1 the weights follow pair-based,
// trace-weighted STDP:
//   * potentiation by (pre_trace >> LTP_SHIFT) on a postsynaptic spike;
//   * depression by (post_trace >> LTD_SHIFT) on that channel's presynaptic spike.
// A host port can overwrite one weight per cycle and read any weight back.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   pre_spike  per-channel presynaptic spike pulses [N_CH]
//   post_spike postsynaptic spike from the downstream neuron
//   learn_en   1 enables weight plasticity (traces always run)
//   wr_en      host write strobe
//   wr_addr    host write channel index (out-of-range writes are dropped)
//   wr_data    host write value, clamped to [W_MIN, W_MAX]
//   rd_addr    host read channel index
//   rd_data    weight[rd_addr], combinational; 0 for out-of-range indices
//   i_syn      registered, saturated, signed synaptic current
// -----------------------------------------------------------------------------
module stdp_synapse_array #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int TRACE_W     = 8,
    parameter int W_INIT      = 16,
    parameter int W_MIN       = 4,
    parameter int W_MAX       = 127,
    parameter int TRACE_INC   = 16,
    parameter int DECAY_SHIFT = 2,
    parameter int LTP_SHIFT   = 3,
    parameter int LTD_SHIFT   = 4,
    parameter int AW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         pre_spike,
    input  logic                    post_spike,
    input  logic                    learn_en,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [AW-1:0]           rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic signed [WIDTH-1:0] i_syn
);

    // Sum width: wide enough that N_CH full-scale weights cannot wrap.
    localparam int SW = WIDTH + AW;

    localparam logic [SW-1:0]          I_MAX_C     = SW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [TRACE_W:0]       TRACE_MAX_C = (TRACE_W + 1)'((64'd1 << TRACE_W) - 64'd1);
    localparam logic [TRACE_W:0]       TRACE_INC_C = (TRACE_W + 1)'(TRACE_INC);
    localparam logic [WIDTH-1:0]       W_INIT_C    = WIDTH'(W_INIT);
    localparam logic [WIDTH-1:0]       W_MIN_C     = WIDTH'(W_MIN);
    localparam logic [WIDTH-1:0]       W_MAX_C     = WIDTH'(W_MAX);
    localparam logic signed [WIDTH+1:0] W_MIN_S    = (WIDTH + 2)'(W_MIN);
    localparam logic signed [WIDTH+1:0] W_MAX_S    = (WIDTH + 2)'(W_MAX);
    localparam logic [AW:0]            N_CH_C      = (AW + 1)'(N_CH);

    // Clamp a signed intermediate weight into [W_MIN, W_MAX].
    function automatic logic [WIDTH-1:0] clamp_w(input logic signed [WIDTH+1:0] v);
        if (v < W_MIN_S) begin
            return W_MIN_C;
        end else if (v > W_MAX_S) begin
            return W_MAX_C;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Next trace value: saturating bump on a spike, otherwise multiplicative
    // decay. Once the decay step rounds to zero the residue is flushed so the
    // trace never sticks at a small non-zero value.
    function automatic logic [TRACE_W-1:0] trace_step(input logic [TRACE_W-1:0] t,
                                                      input logic spike);
        logic [TRACE_W:0]   bumped;
        logic [TRACE_W-1:0] dec;
        bumped = {1'b0, t} + TRACE_INC_C;
        dec    = t >> DECAY_SHIFT;
        if (spike) begin
            if (bumped > TRACE_MAX_C) begin
                return TRACE_MAX_C[TRACE_W-1:0];
            end else begin
                return bumped[TRACE_W-1:0];
            end
        end else if (dec == '0) begin
            return '0;
        end else begin
            return t - dec;
        end
    endfunction

    // One STDP step for a single channel, using pre-edge traces only.
    function automatic logic [WIDTH-1:0] learn_step(input logic [WIDTH-1:0]   w,
                                                    input logic [TRACE_W-1:0] pre_tr,
                                                    input logic [TRACE_W-1:0] post_tr,
                                                    input logic               pre,
                                                    input logic               post);
        logic signed [WIDTH+1:0] ltp;
        logic signed [WIDTH+1:0] ltd;
        logic signed [WIDTH+1:0] acc;
        if (post) begin
            ltp = (WIDTH + 2)'(pre_tr >> LTP_SHIFT);
        end else begin
            ltp = '0;
        end
        if (pre) begin
            ltd = (WIDTH + 2)'(post_tr >> LTD_SHIFT);
        end else begin
            ltd = '0;
        end
        acc = $signed({2'b00, w}) + ltp - ltd;
        return clamp_w(acc);
    endfunction

    logic [WIDTH-1:0]        weight_r       [N_CH];
    logic [TRACE_W-1:0]      pre_trace_r    [N_CH];
    logic [TRACE_W-1:0]      post_trace_r;
    logic signed [WIDTH-1:0] i_syn_r;

    logic [WIDTH-1:0]        weight_nxt_s   [N_CH];
    logic [TRACE_W-1:0]      pre_trace_nxt_s[N_CH];
    logic [TRACE_W-1:0]      post_trace_nxt_s;
    logic [SW-1:0]           sum_s;
    logic signed [WIDTH-1:0] i_syn_nxt_s;

    // Sum the weights of spiking channels and saturate to the positive range.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (pre_spike[k]) begin
                sum_s = sum_s + SW'(weight_r[k]);
            end else begin
                sum_s = sum_s;
            end
        end
        if (sum_s > I_MAX_C) begin
            i_syn_nxt_s = $signed(I_MAX_C[WIDTH-1:0]);
        end else begin
            i_syn_nxt_s = $signed(sum_s[WIDTH-1:0]);
        end
    end

    // Trace next-state; traces run independently of learn_en.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pre_trace_nxt_s[k] = trace_step(pre_trace_r[k], pre_spike[k]);
        end
        post_trace_nxt_s = trace_step(post_trace_r, post_spike);
    end

    // Weight next-state: a host write wins for its own channel only. The
    // equality against an in-range k also drops out-of-range write addresses.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            if (wr_en && (wr_addr == AW'(k))) begin
                weight_nxt_s[k] = clamp_w($signed({2'b00, wr_data}));
            end else if (learn_en) begin
                weight_nxt_s[k] = learn_step(weight_r[k], pre_trace_r[k], post_trace_r,
                                             pre_spike[k], post_spike);
            end else begin
                weight_nxt_s[k] = weight_r[k];
            end
        end
    end

    // Combinational host read port with out-of-range guard.
    always_comb begin
        if ({1'b0, rd_addr} < N_CH_C) begin
            rd_data = weight_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_CH; k++) begin
                weight_r[k]    <= W_INIT_C;
                pre_trace_r[k] <= '0;
            end
            post_trace_r <= '0;
            i_syn_r      <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                weight_r[k]    <= weight_nxt_s[k];
                pre_trace_r[k] <= pre_trace_nxt_s[k];
            end
            post_trace_r <= post_trace_nxt_s;
            i_syn_r      <= i_syn_nxt_s;
        end
    end

    assign i_syn = i_syn_r;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// -----------------------------------------------------------------------------
// tb_stdp_synapse_array
//
// Self-checking bench for stdp_synapse_array (default parameters). A table of
// host/spike vectors with hand-derived expected current and read-back covers
// summation, saturation, clamping and write timing; hand-written sequences
// cover LTP, LTD, learn enable, trace decay/saturation, write priority and an
// asynchronous mid-stream reset. Expected i_syn values go through a queue: they
// are pushed as each cycle is driven and popped when the registered output is
// sampled one clock later.
// -----------------------------------------------------------------------------
module tb_stdp_synapse_array;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_CH-1:0]         pre_spike;
    logic                    post_spike;
    logic                    learn_en;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [AW-1:0]           rd_addr;
    logic [WIDTH-1:0]        rd_data;
    logic signed [WIDTH-1:0] i_syn;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] sb_q[$];

    typedef struct {
        logic [N_CH-1:0]  pre;
        logic             wr;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] exp_isyn;
        logic [WIDTH-1:0] exp_rd;
    } vec_t;

    vec_t vecs[13];
    int   exp_tr[8];

    stdp_synapse_array dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .learn_en   (learn_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .i_syn      (i_syn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Queue the expected current, clock once, then compare the sampled output.
    task automatic tick(input string name, input logic [WIDTH-1:0] exp_isyn);
        sb_q.push_back(exp_isyn);
        @(posedge clk);
        #1;
        check(name, i_syn, sb_q.pop_front());
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] addr,
                            input logic [WIDTH-1:0] exp);
        rd_addr = addr;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic clear_inputs();
        pre_spike  = '0;
        post_spike = 1'b0;
        learn_en   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_addr = '0;
        do_reset();

        // Reset state.
        check("rst_i_syn", i_syn, 32'd0);
        check("rst_post_trace", dut.post_trace_r, 32'd0);
        for (int a = 0; a < N_CH; a++) begin
            read_chk($sformatf("rst_rd%0d", a), AW'(a), 8'd16);
        end

        // Table-driven vectors, learning off. Weights start at 16,16,16,16.
        //            pre      wr    wa     wd      ra     i_syn   rd
        vecs[0]  = '{4'b0011, 1'b0, 2'd0, 8'd0,   2'd0, 8'd32,  8'd16};
        vecs[1]  = '{4'b0000, 1'b0, 2'd0, 8'd0,   2'd3, 8'd0,   8'd16};
        vecs[2]  = '{4'b0000, 1'b1, 2'd0, 8'd200, 2'd0, 8'd0,   8'd127};
        vecs[3]  = '{4'b0000, 1'b1, 2'd1, 8'd0,   2'd1, 8'd0,   8'd4};
        vecs[4]  = '{4'b1111, 1'b0, 2'd0, 8'd0,   2'd2, 8'd127, 8'd16};
        vecs[5]  = '{4'b0110, 1'b1, 2'd3, 8'd100, 2'd3, 8'd20,  8'd100};
        vecs[6]  = '{4'b1000, 1'b0, 2'd0, 8'd0,   2'd0, 8'd100, 8'd127};
        vecs[7]  = '{4'b0101, 1'b1, 2'd2, 8'd4,   2'd2, 8'd127, 8'd4};
        vecs[8]  = '{4'b0100, 1'b1, 2'd0, 8'd127, 2'd0, 8'd4,   8'd127};
        vecs[9]  = '{4'b0010, 1'b1, 2'd1, 8'd3,   2'd1, 8'd4,   8'd4};
        vecs[10] = '{4'b1010, 1'b1, 2'd3, 8'd128, 2'd3, 8'd104, 8'd127};
        vecs[11] = '{4'b1001, 1'b1, 2'd2, 8'd255, 2'd2, 8'd127, 8'd127};
        vecs[12] = '{4'b1101, 1'b0, 2'd0, 8'd0,   2'd1, 8'd127, 8'd4};
        for (int i = 0; i < 13; i++) begin
            pre_spike = vecs[i].pre;
            wr_en     = vecs[i].wr;
            wr_addr   = vecs[i].wa;
            wr_data   = vecs[i].wd;
            rd_addr   = vecs[i].ra;
            tick($sformatf("vec%0d_i_syn", i), vecs[i].exp_isyn);
            check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
        end
        clear_inputs();
        tick("vec_idle_i_syn", 8'd0);

        // LTP: pre on ch0, post one cycle later -> 16 + (16 >> 3) = 18.
        do_reset();
        learn_en  = 1'b1;
        pre_spike = 4'b0001;
        tick("ltp_pre_i_syn", 8'd16);
        pre_spike  = 4'b0000;
        post_spike = 1'b1;
        tick("ltp_post_i_syn", 8'd0);
        post_spike = 1'b0;
        read_chk("ltp_w0", 2'd0, 8'd18);
        read_chk("ltp_w1", 2'd1, 8'd16);
        read_chk("ltp_w2", 2'd2, 8'd16);
        read_chk("ltp_w3", 2'd3, 8'd16);

        // LTD: post first, pre on ch1 one cycle later -> 16 - (16 >> 4) = 15.
        do_reset();
        learn_en   = 1'b1;
        post_spike = 1'b1;
        tick("ltd_post_i_syn", 8'd0);
        check("ltd_post_trace", dut.post_trace_r, 32'd16);
        post_spike = 1'b0;
        pre_spike  = 4'b0010;
        tick("ltd_pre_i_syn", 8'd16);
        pre_spike = 4'b0000;
        read_chk("ltd_w1", 2'd1, 8'd15);
        read_chk("ltd_w0", 2'd0, 8'd16);

        // Same stimulus with learning disabled: weight holds.
        do_reset();
        post_spike = 1'b1;
        tick("noln_post_i_syn", 8'd0);
        post_spike = 1'b0;
        pre_spike  = 4'b0010;
        tick("noln_pre_i_syn", 8'd16);
        pre_spike = 4'b0000;
        read_chk("noln_w1", 2'd1, 8'd16);

        // Trace decay after a single spike on ch2.
        do_reset();
        exp_tr = '{12, 9, 7, 6, 5, 4, 3, 0};
        pre_spike = 4'b0100;
        tick("decay_spike_i_syn", 8'd16);
        check("decay_tr_0", dut.pre_trace_r[2], 32'd16);
        pre_spike = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick($sformatf("decay_i_syn_%0d", i + 1), 8'd0);
            check($sformatf("decay_tr_%0d", i + 1), dut.pre_trace_r[2], 32'(exp_tr[i]));
        end

        // Back-to-back spikes saturate the trace.
        pre_spike = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick($sformatf("sat_tr_i_syn_%0d", i), 8'd16);
        end
        pre_spike = 4'b0000;
        check("sat_tr_255", dut.pre_trace_r[2], 32'd255);

        // LTP on a weight already at W_MAX stays clamped.
        do_reset();
        learn_en  = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 2'd0;
        wr_data   = 8'd127;
        pre_spike = 4'b0001;
        tick("clamp_wr_i_syn", 8'd16);
        wr_en      = 1'b0;
        pre_spike  = 4'b0000;
        post_spike = 1'b1;
        tick("clamp_post_i_syn", 8'd0);
        post_spike = 1'b0;
        read_chk("clamp_w0", 2'd0, 8'd127);
        read_chk("clamp_w1", 2'd1, 8'd16);

        // Host write wins on ch0 while ch1 still potentiates on the same edge.
        do_reset();
        learn_en  = 1'b1;
        pre_spike = 4'b0011;
        tick("prio_pre_i_syn", 8'd32);
        pre_spike  = 4'b0000;
        post_spike = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 2'd0;
        wr_data    = 8'd50;
        tick("prio_post_i_syn", 8'd0);
        wr_en      = 1'b0;
        post_spike = 1'b0;
        read_chk("prio_w0", 2'd0, 8'd50);
        read_chk("prio_w1", 2'd1, 8'd18);
        read_chk("prio_w2", 2'd2, 8'd16);

        // Build up activity, then reset asynchronously between edges.
        pre_spike = 4'b0011;
        tick("mid_pre_i_syn", 8'd68);
        pre_spike = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_i_syn", i_syn, 32'd0);
        check("mid_rst_tr0", dut.pre_trace_r[0], 32'd0);
        check("mid_rst_tr1", dut.pre_trace_r[1], 32'd0);
        check("mid_rst_post_tr", dut.post_trace_r, 32'd0);
        for (int a = 0; a < N_CH; a++) begin
            read_chk($sformatf("mid_rst_w%0d", a), AW'(a), 8'd16);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick("post_rst_i_syn", 8'd0);
        read_chk("post_rst_w0", 2'd0, 8'd16);
        read_chk("post_rst_w1", 2'd1, 8'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
